dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter in front of the single-port, byte-addressed data memory in the MEM stage. Port 0 is the pipeline MEM stage. Port 1 is the debug/program-loader master. The block grants at most one word access per cycle and drives the memory's read/write strobes. It registers read data back to the winning port and rejects out-of-range accesses with an error response instead of touching memory.

## Interface
- `MEM_BYTES`, default 128: data memory size in bytes. A word access is legal only when `addr + 3 < MEM_BYTES`.
- `DATA_W`, default 32: data word width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pN_req` in 1 (N = 0, 1): access request. Must be held with `pN_we`, `pN_addr`, `pN_wdata` stable until `pN_gnt`.
- `pN_we` in 1: 1 means write, 0 means read.
- `pN_addr` in 32: byte address.
- `pN_wdata` in `DATA_W`: write data.
- `pN_lock` in 1: keep the grant on this port for following cycles while asserted.
- `pN_gnt` out 1: request accepted this cycle (combinational).
- `pN_rvalid` out 1: response valid, one cycle after the grant.
- `pN_rdata` out `DATA_W`: read data, valid with `pN_rvalid`; 0 for writes and errors.
- `pN_err` out 1: out-of-range access, valid with `pN_rvalid`.
- `m_address` out 32, `m_writeData` out `DATA_W`, `m_memRead` out 1, `m_memWrite` out 1: memory command.
- `m_memData` in `DATA_W`: combinational read data from memory.

## Operation
- **Arbitration (combinational):**
  - If the lock owner's `req` is high, that port wins.
  - Otherwise, the only requesting port wins.
  - Otherwise, on a tie, priority is set by the policy in the Configuration section.
  - At most one `gnt` per cycle.
- **Range check:**
  - A granted access with `addr + 3 >= MEM_BYTES` still gets `gnt`.
  - `m_memRead` and `m_memWrite` stay 0 for that access.
  - The response carries `err = 1` and `rdata = 0`.
  - The addition is done in 33 bits so that `addr = 0xFFFFFFFF` does not wrap to legal.
- **Memory drive:**
  - Granted legal read: `m_memRead = 1`.
  - Granted legal write: `m_memWrite = 1`.
  - `m_address` and `m_writeData` come from the winning port.
  - With no grant, all `m_*` outputs are 0.
- **Response register:** on every grant, register the owner, the `rdata` (`m_memData` for legal reads, otherwise 0) and `err`. Next cycle, pulse `rvalid` on that port only.
- **Lock state machine:**
  - States: UNLOCKED, LOCKED0, LOCKED1.
  - UNLOCKED to LOCKEDn: on a grant to port n with `pn_lock = 1`.
  - LOCKEDn to UNLOCKED: on the first cycle `pn_lock = 0`. The grant in that cycle is still arbitrated normally.
  - In LOCKEDn, the other port gets no grant while `pn_req = 1`.
  - If the lock owner drops `req` but keeps `lock`, the other port may be granted, and the state stays LOCKEDn.

## Timing
- Grant latency is 0 cycles: `gnt` is in the same cycle as `req` when the port wins. Write data lands in memory at that clock edge.
- Response latency is exactly 1 cycle after `gnt`. Throughput is 1 access per cycle with back-to-back grants.
- Reset values: all `gnt`, `rvalid` and `err` are 0, all `rdata` are 0, all `m_*` outputs are 0, lock state is UNLOCKED, and the round-robin pointer selects port 0.
- Reset asserted mid-operation:
  - No `gnt` and no memory strobe while `reset = 1`.
  - A pending `rvalid` is cleared at the reset edge.
  - Lock state returns to UNLOCKED.
- Simultaneous requests while UNLOCKED are resolved purely by the tie policy.
- A requester may deassert `req` only after `gnt`.

## Configuration
- `DMEM_ARB_RR_EN`:
  - Defined: round-robin ties. The pointer flips to the other port after each tied grant; non-tie grants do not move it.
  - Undefined: fixed priority, port 0 (pipeline) always wins ties, and the pointer register is not built.

## Structure
- Package `dmem_arb_pkg`:
  - `typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_state_t`.
  - `localparam int NUM_PORTS = 2`.
  - Response struct `dmem_rsp_t {owner, rdata, err}`.
- One sub-module, `dmem_arb_rr`: pure 2-way tie picker with a pointer register, built only under `DMEM_ARB_RR_EN`.

## Test plan
- Port 0 writes `0xDEADBEEF` to addr 20, then reads addr 20 → next-cycle `p0_rvalid = 1`, `p0_rdata = 0xDEADBEEF`, `p0_err = 0`.
- Both ports read in the same cycle, macro undefined → `p0_gnt` first; `p1_gnt` next cycle; the two `rvalid` pulses are in consecutive cycles. Macro defined, 4 tied cycles → grants alternate 0, 1, 0, 1.
- Port 1 asserts lock and writes addr 0, 4, 8 while port 0 requests → port 0 is stalled for 3 cycles. It is granted in the cycle port 1 drops `lock` and `req`.
- Port 0 reads addr 125 (and separately `0xFFFFFFFF`) → `gnt = 1`, `m_memRead = 0`, next-cycle `err = 1`, `rdata = 0`.
- `reset` is asserted in the cycle after a port 1 grant while port 1 holds `lock` → `p1_rvalid` is 0 after the edge and lock state is UNLOCKED. Port 0 is granted in the first cycle after `reset` deasserts.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: lock states, response record
// and the word range check used on every granted access.
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;

  // Response record storage width; the top casts to and from its DATA_W,
  // so DATA_W must not exceed this.
  localparam int RSP_DATA_W = 64;

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED0,
    LOCKED1
  } lock_state_t;

  typedef struct packed {
    logic                  owner;  // 0: port 0, 1: port 1
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
  } dmem_rsp_t;

  // A word at addr is legal when its last byte is inside memory. The sum is
  // formed in 33 bits so addresses near 2^32 cannot wrap into range.
  function automatic logic word_in_range(input logic [31:0]   addr,
                                         input int unsigned mem_bytes);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    return last_byte < 33'(mem_bytes);
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way tie picker: a single pointer bit naming the port that wins the
// next tie. It flips after each tied grant; non-tie cycles leave it alone.
// Only built when DMEM_ARB_RR_EN is defined.
`ifdef DMEM_ARB_RR_EN
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tie,
  output logic pick
);

  logic ptr_q;
  logic ptr_d;

  // Next pointer: hand the following tie to the other port.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    ptr_d = ptr_q;
    if (tie) begin
      ptr_d = ~ptr_q;
    end
  end

  // Pointer register, port 0 first after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign pick = ptr_q;

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port byte-addressed data memory.
// Port 0 is the pipeline MEM stage, port 1 the debug/loader master. Grants
// are combinational, out-of-range words are answered with err instead of
// reaching memory, and the response is registered one cycle after grant.
// Optional feature: define DMEM_ARB_RR_EN for round-robin ties; otherwise
// port 0 wins every tie and no pointer register exists.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,

  output logic [31:0]       m_address,
  output logic [DATA_W-1:0] m_writeData,
  output logic              m_memRead,
  output logic              m_memWrite,
  input  logic [DATA_W-1:0] m_memData
);

  lock_state_t          state_q, state_d;
  dmem_rsp_t            rsp_q, rsp_d;
  logic                 rvalid_q, rvalid_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic                 any_gnt;
  logic                 tie;
  logic                 tie_pick;

  logic                 win_we;
  logic [31:0]          win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic                 win_legal;

  assign req = {p1_req, p0_req};

`ifdef DMEM_ARB_RR_EN
  dmem_arb_rr u_rr (
    .clk   (clk),
    .reset (reset),
    .tie   (tie),
    .pick  (tie_pick)
  );
`else
  logic unused_tie;
  assign unused_tie = tie;
  assign tie_pick   = 1'b0;
`endif

  // Arbitration: lock owner first, then a lone requester, then tie policy.
  always_comb begin
    gnt = '0;
    tie = 1'b0;
    if (!reset) begin
      if (state_q == LOCKED0 && req[0]) begin
        gnt = 2'b01;
      end else if (state_q == LOCKED1 && req[1]) begin
        gnt = 2'b10;
      end else if (req == 2'b01) begin
        gnt = 2'b01;
      end else if (req == 2'b10) begin
        gnt = 2'b10;
      end else if (req == 2'b11) begin
        tie = 1'b1;
        gnt = tie_pick ? 2'b10 : 2'b01;
      end
    end
  end

  assign any_gnt = |gnt;
  assign p0_gnt  = gnt[0];
  assign p1_gnt  = gnt[1];

  // Winner mux, range check and memory command.
  always_comb begin
    win_we      = gnt[1] ? p1_we    : p0_we;
    win_addr    = gnt[1] ? p1_addr  : p0_addr;
    win_wdata   = gnt[1] ? p1_wdata : p0_wdata;
    win_legal   = word_in_range(win_addr, MEM_BYTES);

    m_address   = any_gnt ? win_addr  : '0;
    m_writeData = any_gnt ? win_wdata : '0;
    m_memRead   = any_gnt && win_legal && !win_we;
    m_memWrite  = any_gnt && win_legal &&  win_we;
  end

  // Response capture: owner, read data (legal reads only) and error flag.
  always_comb begin
    rvalid_d    = any_gnt;
    rsp_d.owner = gnt[1];
    rsp_d.err   = any_gnt && !win_legal;
    rsp_d.rdata = m_memRead ? RSP_DATA_W'(m_memData) : '0;
  end

  // Lock state machine: enter on a locked grant, leave when lock drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UNLOCKED: begin
        if (gnt[0] && p0_lock) begin
          state_d = LOCKED0;
        end else if (gnt[1] && p1_lock) begin
          state_d = LOCKED1;
        end
      end
      LOCKED0:  if (!p0_lock) state_d = UNLOCKED;
      LOCKED1:  if (!p1_lock) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      rvalid_q <= 1'b0;
      // NOTE: the response payload is reset as well, not just its valid,
      // because rdata and err have defined values out of reset.
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rsp_q    <= rsp_d;
    end
  end

  // Steer the registered response to its owner; the other port sees zeros.
  always_comb begin
    p0_rvalid = rvalid_q && !rsp_q.owner;
    p1_rvalid = rvalid_q &&  rsp_q.owner;
    p0_rdata  = p0_rvalid ? DATA_W'(rsp_q.rdata) : '0;
    p1_rdata  = p1_rvalid ? DATA_W'(rsp_q.rdata) : '0;
    p0_err    = p0_rvalid && rsp_q.err;
    p1_err    = p1_rvalid && rsp_q.err;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a vector table of per-cycle port
// stimulus with expected grants, a byte-array memory model, and a queue of
// expected responses pushed at grant time and popped one cycle later.
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 128;
  localparam int DATA_W    = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              p0_req = 0, p0_we = 0, p0_lock = 0;
  logic [31:0]       p0_addr = '0;
  logic [DATA_W-1:0] p0_wdata = '0;
  logic              p1_req = 0, p1_we = 0, p1_lock = 0;
  logic [31:0]       p1_addr = '0;
  logic [DATA_W-1:0] p1_wdata = '0;
  logic              p0_gnt, p0_rvalid, p0_err;
  logic              p1_gnt, p1_rvalid, p1_err;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [31:0]       m_address;
  logic [DATA_W-1:0] m_writeData, m_memData;
  logic              m_memRead, m_memWrite;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_lock(p0_lock), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .m_address(m_address), .m_writeData(m_writeData),
    .m_memRead(m_memRead), .m_memWrite(m_memWrite), .m_memData(m_memData)
  );

  always #5 clk = ~clk;

  // Memory model (little-endian bytes) and the bench's own shadow copy.
  logic [7:0] mem [MEM_BYTES];
  logic [7:0] shadow [MEM_BYTES];

  always_comb begin
    int b;
    b = int'(m_address[6:0]);
    m_memData = '0;
    if (m_address < 32'd125) m_memData = {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  end

  always @(posedge clk) begin
    int b;
    b = int'(m_address[6:0]);
    if (m_memWrite && m_address < 32'd125) begin
      mem[b] <= m_writeData[7:0];   mem[b+1] <= m_writeData[15:8];
      mem[b+2] <= m_writeData[23:16]; mem[b+3] <= m_writeData[31:24];
    end
  end

  typedef struct {
    logic r0, we0, l0; logic [31:0] a0, d0;
    logic r1, we1, l1; logic [31:0] a1, d1;
    logic rst, eg0, eg1;
  } vec_t;

  typedef struct { logic port; logic [31:0] rdata; logic err; } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  function automatic vec_t v(input logic r0, we0, input logic [31:0] a0, d0, input logic l0,
                             input logic r1, we1, input logic [31:0] a1, d1, input logic l1,
                             input logic rst, eg0, eg1);
    vec_t x;
    x.r0 = r0; x.we0 = we0; x.a0 = a0; x.d0 = d0; x.l0 = l0;
    x.r1 = r1; x.we1 = we1; x.a1 = a1; x.d1 = d1; x.l1 = l1;
    x.rst = rst; x.eg0 = eg0; x.eg1 = eg1;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] shadow_word(input logic [31:0] a);
    int b;
    b = int'(a[6:0]);
    return {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
  endfunction

  // One clock: drive inputs after the edge, check at the falling edge.
  task automatic cycle(input vec_t x);
    exp_t        e;
    string       n;
    logic        eg_any, wwe, lg;
    logic [31:0] wa, wd;
    @(posedge clk); #1;
    reset = x.rst;
    p0_req = x.r0; p0_we = x.we0; p0_addr = x.a0; p0_wdata = x.d0; p0_lock = x.l0;
    p1_req = x.r1; p1_we = x.we1; p1_addr = x.a1; p1_wdata = x.d1; p1_lock = x.l1;
    @(negedge clk);
    n = $sformatf("c%0d", cyc);
    cyc++;

    check({n, ".p0_gnt"}, 64'(p0_gnt), 64'(x.eg0));
    check({n, ".p1_gnt"}, 64'(p1_gnt), 64'(x.eg1));
    eg_any = x.eg0 | x.eg1;
    wwe = x.eg1 ? x.we1 : x.we0;
    wa  = x.eg1 ? x.a1  : x.a0;
    wd  = x.eg1 ? x.d1  : x.d0;
    lg  = (64'(wa) + 64'd3) < 64'(MEM_BYTES);
    check({n, ".m_memRead"},   64'(m_memRead),   64'(eg_any && lg && !wwe));
    check({n, ".m_memWrite"},  64'(m_memWrite),  64'(eg_any && lg && wwe));
    check({n, ".m_address"},   64'(m_address),   eg_any ? 64'(wa) : 64'd0);
    check({n, ".m_writeData"}, 64'(m_writeData), eg_any ? 64'(wd) : 64'd0);

    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({n, ".p0_rvalid"}, 64'(p0_rvalid), 64'(!e.port));
      check({n, ".p1_rvalid"}, 64'(p1_rvalid), 64'(e.port));
      check({n, ".rdata"}, e.port ? 64'(p1_rdata) : 64'(p0_rdata), 64'(e.rdata));
      check({n, ".err"},   e.port ? 64'(p1_err)   : 64'(p0_err),   64'(e.err));
    end else begin
      check({n, ".p0_rvalid"}, 64'(p0_rvalid), 64'd0);
      check({n, ".p1_rvalid"}, 64'(p1_rvalid), 64'd0);
    end

    if (eg_any) begin
      e.port  = x.eg1;
      e.err   = !lg;
      e.rdata = (lg && !wwe) ? shadow_word(wa) : 32'd0;
      if (lg && wwe) begin
        int b;
        b = int'(wa[6:0]);
        shadow[b] = wd[7:0];     shadow[b+1] = wd[15:8];
        shadow[b+2] = wd[23:16]; shadow[b+3] = wd[31:24];
      end
      exp_q.push_back(e);
    end
  endtask

  initial begin
    logic w;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i]    = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end

    // Reset and reset-value checks.
    cycle(v(0,0,0,0,0, 0,0,0,0,0, 1, 0,0));
    cycle(v(0,0,0,0,0, 0,0,0,0,0, 1, 0,0));
    check("rst.p0_rdata", 64'(p0_rdata), 64'd0);
    check("rst.p1_rdata", 64'(p1_rdata), 64'd0);
    check("rst.p0_err",   64'(p0_err),   64'd0);
    check("rst.p1_err",   64'(p1_err),   64'd0);

    //               p0: req we addr         wdata        lk  p1: req we addr  wdata        lk  rst g0 g1
    vecs.push_back(v(1,1,32'd20,        32'hDEADBEEF,0, 0,0,32'd0,  32'd0,       0, 0, 1,0)); // write 20
    vecs.push_back(v(1,0,32'd20,        32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 1,0)); // read 20
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 0,0));
    vecs.push_back(v(1,0,32'd20,        32'd0,       0, 1,0,32'd124,32'd0,       0, 0, 1,0)); // tie
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 1,0,32'd124,32'd0,       0, 0, 0,1));
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 0,0));
    vecs.push_back(v(1,0,32'd125,       32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 1,0)); // range
    vecs.push_back(v(1,0,32'hFFFFFFFF,  32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 1,0)); // wrap
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 1,1,32'd200,32'h1234,    0, 0, 0,1));
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 1,1,32'd124,32'hCAFEF00D,0, 0, 0,1)); // edge
    vecs.push_back(v(1,0,32'd124,       32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 1,0));
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 0,0));
    // Port 1 locked burst; port 0 stalls three cycles, then wins on release.
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 1,1,32'd0,  32'h11111111,1, 0, 0,1));
    vecs.push_back(v(1,0,32'd0,         32'd0,       0, 1,1,32'd4,  32'h22222222,1, 0, 0,1));
    vecs.push_back(v(1,0,32'd0,         32'd0,       0, 1,1,32'd8,  32'h33333333,1, 0, 0,1));
    vecs.push_back(v(1,0,32'd0,         32'd0,       0, 1,1,32'd12, 32'h44444444,1, 0, 0,1));
    vecs.push_back(v(1,0,32'd0,         32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 1,0));
    // Owner idles with lock held: port 0 passes, lock persists.
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 1,1,32'd16, 32'h55555555,1, 0, 0,1));
    vecs.push_back(v(1,0,32'd4,         32'd0,       0, 0,0,32'd0,  32'd0,       1, 0, 1,0));
    vecs.push_back(v(1,0,32'd8,         32'd0,       0, 1,1,32'd28, 32'h66666666,1, 0, 0,1));
    vecs.push_back(v(1,0,32'd8,         32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 1,0));
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 0,0));
    // Reset while port 1 holds the lock.
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 1,1,32'd32, 32'h77777777,1, 0, 0,1));
    vecs.push_back(v(1,0,32'd32,        32'd0,       0, 1,1,32'd36, 32'h88888888,1, 1, 0,0));
    vecs.push_back(v(1,0,32'd32,        32'd0,       0, 1,1,32'd36, 32'h88888888,1, 0, 1,0));
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 1,1,32'd36, 32'h88888888,1, 0, 0,1));
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 0,0));
    vecs.push_back(v(0,0,32'd0,         32'd0,       0, 0,0,32'd0,  32'd0,       0, 0, 0,0));

    foreach (vecs[i]) cycle(vecs[i]);

    // Four tied cycles straight after reset.
    cycle(v(0,0,0,0,0, 0,0,0,0,0, 1, 0,0));
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      w = i[0];
`else
      w = 1'b0;
`endif
      cycle(v(1,0,32'd40,32'd0,0, 1,0,32'd60,32'd0,0, 0, !w, w));
    end
    cycle(v(0,0,0,0,0, 0,0,0,0,0, 0, 0,0));
    cycle(v(0,0,0,0,0, 0,0,0,0,0, 0, 0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
